// File: rtl/lsu_dbus_if.sv
// Load/store unit front end for the data bus: checks RV32 alignment and funct3,
// issues one bus access per command, then returns extended load data and fault flags.
module lsu_dbus_if #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_funct3_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_busy_o,
  output logic            lsu_valid_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_ld_misalign_o,
  output logic            lsu_st_misalign_o,
  output logic            lsu_bus_err_o,
  output logic            dbus_req_o,
  output logic            dbus_w_en_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [XLEN-1:0] dbus_w_data_o,
  output logic [3:0]      dbus_sel_byte_o,
  input  logic            dbus_ack_i,
  input  logic [XLEN-1:0] dbus_r_data_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  // only the fields still needed after the bus outputs are loaded
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } cmd_t;

  state_t          state;
  cmd_t            cmd;
  logic [7:0]      cnt;

  logic            in_illegal, in_misalign;
  logic [3:0]      in_sel;
  logic [XLEN-1:0] in_wdata;
  logic [XLEN-1:0] ld_shift, ld_ext;

  always_comb begin
    in_illegal  = lsu_we_i ? (lsu_funct3_i > 3'b010)
                           : (lsu_funct3_i == 3'b011 || lsu_funct3_i[2:1] == 2'b11);
    in_misalign = (lsu_funct3_i[1:0] == 2'b01 && lsu_addr_i[0]) ||
                  (lsu_funct3_i[1:0] == 2'b10 && lsu_addr_i[1:0] != 2'b00);
    case (lsu_funct3_i[1:0])
      2'b00:   begin
        in_sel   = 4'b0001 << lsu_addr_i[1:0];
        in_wdata = {(XLEN/8){lsu_wdata_i[7:0]}};
      end
      2'b01:   begin
        in_sel   = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        in_wdata = {(XLEN/16){lsu_wdata_i[15:0]}};
      end
      default: begin
        in_sel   = 4'b1111;
        in_wdata = lsu_wdata_i;
      end
    endcase
  end

  always_comb begin
    ld_shift = dbus_r_data_i >> {cmd.addr_lo, 3'b000};
    case (cmd.funct3)
      3'b000:  ld_ext = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
      default: ld_ext = dbus_r_data_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cmd               <= '0;
      cnt               <= '0;
      lsu_busy_o        <= 1'b0;
      lsu_valid_o       <= 1'b0;
      lsu_rdata_o       <= '0;
      lsu_ld_misalign_o <= 1'b0;
      lsu_st_misalign_o <= 1'b0;
      lsu_bus_err_o     <= 1'b0;
      dbus_req_o        <= 1'b0;
      dbus_w_en_o       <= 1'b0;
      dbus_addr_o       <= '0;
      dbus_w_data_o     <= '0;
      dbus_sel_byte_o   <= '0;
    end else begin
      lsu_valid_o       <= 1'b0;
      lsu_rdata_o       <= '0;
      lsu_ld_misalign_o <= 1'b0;
      lsu_st_misalign_o <= 1'b0;
      lsu_bus_err_o     <= 1'b0;
      dbus_req_o        <= 1'b0;
      case (state)
        IDLE: if (lsu_req_i) begin
          cmd        <= '{we: lsu_we_i, funct3: lsu_funct3_i, addr_lo: lsu_addr_i[1:0]};
          lsu_busy_o <= 1'b1;
          if (in_illegal || in_misalign) begin
            // faulting commands never touch the bus
            state             <= RESP;
            lsu_valid_o       <= 1'b1;
            lsu_bus_err_o     <= in_illegal;
            lsu_ld_misalign_o <= !in_illegal && in_misalign && !lsu_we_i;
            lsu_st_misalign_o <= !in_illegal && in_misalign && lsu_we_i;
          end else begin
            state           <= REQ;
            dbus_req_o      <= 1'b1;
            dbus_w_en_o     <= lsu_we_i;
            dbus_addr_o     <= {lsu_addr_i[XLEN-1:2], 2'b00};
            dbus_w_data_o   <= in_wdata;
            dbus_sel_byte_o <= in_sel;
          end
        end
        REQ: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          // ack is checked before the timeout so a last-cycle ack still completes
          if (dbus_ack_i || cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            state           <= RESP;
            lsu_valid_o     <= 1'b1;
            lsu_bus_err_o   <= !dbus_ack_i;
            lsu_rdata_o     <= (dbus_ack_i && !cmd.we) ? ld_ext : '0;
            dbus_w_en_o     <= 1'b0;
            dbus_addr_o     <= '0;
            dbus_w_data_o   <= '0;
            dbus_sel_byte_o <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          lsu_busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
